wb_analog_ctrl: RTL and testbench

WB_ANALOG_CTRL -- requirements
Module: wb_analog_ctrl

---
 rtl/wb_analog_ctrl.sv | 162 ++++++++++++++++
 tb/tb_wb_analog_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_analog_ctrl.sv
// wb_analog_ctrl: Wishbone slave register block for analog enable, trim,
// status and interrupt control. One wait state per transfer: IDLE -> ACK.
// Optional feature macro: WB_ANALOG_TIMER_EN adds a 32-bit timer (0x18)
// with compare/wrap (0x1C) feeding IRQ_STAT[4]; without it the timer
// offsets read 0 and no counter flops exist.
module wb_analog_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [3:0]  status_i,
    output logic [7:0]  ctrl_o,
    output logic [15:0] trim_o,
    output logic        irq_o
);

    localparam logic [31:0] ID_VALUE = 32'hF07C_0001;

    typedef enum logic {IDLE, ACK} state_t;

    state_t      state;
    state_t      state_next;
    logic        req;
    logic        commit;
    logic        wr;
    logic [5:0]  word;
    logic [31:0] wmask;
    logic [31:0] rdata;
    logic [7:0]  ctrl;
    logic [15:0] trim;
    logic [3:0]  status_prev;
    logic [4:0]  irq_stat;
    logic [4:0]  irq_mask;
    logic [4:0]  irq_set;
    logic [4:0]  irq_clr;
    logic        timer_hit;
    logic [31:0] timer_rd;
    logic [31:0] cmp_rd;
    logic        unused_bits;

    assign req    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign commit = (state == IDLE) & req;
    assign wr     = commit & wbs_we_i;
    assign word   = wbs_adr_i[7:2];
    assign wmask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                     {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    // Byte address bits and upper data/mask lanes only matter in some builds.
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wmask[31:16]};

    // W1C clear strobe and edge/timer set sources for IRQ_STAT.
    assign irq_clr = (wr && word == 6'd4) ? (wbs_dat_i[4:0] & wmask[4:0]) : 5'd0;
    assign irq_set = {timer_hit, status_i & ~status_prev};

    // State register; reset drops any transfer in flight.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state: accept a request from IDLE, always return from ACK.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign wbs_ack_o = (state == ACK);

    // Read mux over the register map; unmapped words return 0.
    always_comb begin
        rdata = 32'd0;
        case (word)
            6'd0:    rdata = ID_VALUE;
            6'd1:    rdata = {24'd0, ctrl};
            6'd2:    rdata = {16'd0, trim};
            6'd3:    rdata = {28'd0, status_i};
            6'd4:    rdata = {27'd0, irq_stat};
            6'd5:    rdata = {27'd0, irq_mask};
            6'd6:    rdata = timer_rd;
            6'd7:    rdata = cmp_rd;
            default: rdata = 32'd0;
        endcase
    end

    // Read data is captured as the transfer is accepted and zero otherwise.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)    wbs_dat_o <= 32'd0;
        else if (commit) wbs_dat_o <= rdata;
        else             wbs_dat_o <= 32'd0;
    end

    // Writable configuration registers, merged per byte lane.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl     <= 8'd0;
            trim     <= 16'd0;
            irq_mask <= 5'd0;
        end else if (wr) begin
            if (word == 6'd1) ctrl     <= (ctrl & ~wmask[7:0]) | (wbs_dat_i[7:0] & wmask[7:0]);
            if (word == 6'd2) trim     <= (trim & ~wmask[15:0]) | (wbs_dat_i[15:0] & wmask[15:0]);
            if (word == 6'd5) irq_mask <= (irq_mask & ~wmask[4:0]) | (wbs_dat_i[4:0] & wmask[4:0]);
        end
    end

    // Interrupt status: set wins over a same-cycle W1C clear.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            status_prev <= 4'd0;
            irq_stat    <= 5'd0;
        end else begin
            status_prev <= status_i;
            irq_stat    <= (irq_stat & ~irq_clr) | irq_set;
        end
    end

    // Interrupt line registered from the current masked status.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) irq_o <= 1'b0;
        else          irq_o <= |(irq_stat & irq_mask);
    end

`ifdef WB_ANALOG_TIMER_EN
    logic [31:0] timer;
    logic [31:0] cmp;

    assign timer_hit = (timer == cmp) && (cmp != 32'd0);
    assign timer_rd  = timer;
    assign cmp_rd    = cmp;

    // Free-running timer that wraps to 0 one cycle after matching CMP.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            timer <= 32'd0;
            cmp   <= 32'd0;
        end else begin
            if (timer_hit) timer <= 32'd0;
            else           timer <= timer + 32'd1;
            if (wr && word == 6'd7) cmp <= (cmp & ~wmask) | (wbs_dat_i & wmask);
        end
    end
`else
    assign timer_hit = 1'b0;
    assign timer_rd  = 32'd0;
    assign cmp_rd    = 32'd0;
`endif

    assign ctrl_o = ctrl;
    assign trim_o = trim;

endmodule

// File: tb/tb_wb_analog_ctrl.sv
// Directed testbench for wb_analog_ctrl: register access, byte lanes,
// edge interrupts, W1C priority, address decode, back-to-back acks,
// reset abort and the optional timer (WB_ANALOG_TIMER_EN).
module tb_wb_analog_ctrl;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] dat_o;
    logic [3:0]  status;
    logic [7:0]  ctrl;
    logic [15:0] trim;
    logic        irq;

    int checks = 0;
    int errors = 0;

    wb_analog_ctrl dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_sel_i(sel),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .status_i (status),
        .ctrl_o   (ctrl),
        .trim_o   (trim),
        .irq_o    (irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus transfer; returns data and ack latency (-1 when no ack in 8 cycles).
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output int lat);
        @(negedge wb_clk_i);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        lat = -1;
        r = 32'd0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge wb_clk_i); #1;
            if (ack === 1'b1) begin
                lat = i;
                r = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
        checks++; if (dat_o !== 32'd0) begin errors++; $display("FAIL reset_dat: got %h expected 0", dat_o); end
        checks++; if (ctrl !== 8'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", ctrl); end
        checks++; if (trim !== 16'd0) begin errors++; $display("FAIL reset_trim: got %h expected 0", trim); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
    endtask

    task automatic test_timer();
        logic [31:0] r;
        int lat;
`ifdef WB_ANALOG_TIMER_EN
        wb_xfer(1'b1, 32'h3000_001C, 32'd5, 4'hF, r, lat);
        repeat (20) @(posedge wb_clk_i);
        wb_xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF, r, lat);
        checks++; if (r[4] !== 1'b1) begin errors++; $display("FAIL timer_irq: got %h expected bit4 set", r); end
        for (int k = 0; k < 3; k++) begin
            wb_xfer(1'b0, 32'h3000_0018, 32'd0, 4'hF, r, lat);
            checks++; if (r > 32'd5) begin errors++; $display("FAIL timer_range: got %0d expected 0..5", r); end
        end
        wb_xfer(1'b0, 32'h3000_001C, 32'd0, 4'hF, r, lat);
        checks++; if (r !== 32'd5) begin errors++; $display("FAIL timer_cmp: got %h expected 5", r); end
        wb_xfer(1'b1, 32'h3000_001C, 32'd0, 4'hF, r, lat);
        wb_xfer(1'b1, 32'h3000_0010, 32'h1F, 4'h1, r, lat);
        wb_xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF, r, lat);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL timer_clr: got %h expected 0", r); end
`else
        wb_xfer(1'b1, 32'h3000_001C, 32'd5, 4'hF, r, lat);
        wb_xfer(1'b0, 32'h3000_0018, 32'd0, 4'hF, r, lat);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL timer_off_rd: got %h expected 0", r); end
        wb_xfer(1'b0, 32'h3000_001C, 32'd0, 4'hF, r, lat);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL cmp_off_rd: got %h expected 0", r); end
        repeat (10) @(posedge wb_clk_i);
        wb_xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF, r, lat);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL timer_off_irq: got %h expected 0", r); end
`endif
    endtask

    task automatic test_id();
        logic [31:0] r;
        int lat;
        wb_xfer(1'b0, 32'h3000_0000, 32'd0, 4'hF, r, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL id_latency: got %0d expected 1", lat); end
        checks++; if (r !== 32'hF07C_0001) begin errors++; $display("FAIL id_data: got %h expected f07c0001", r); end
        checks++; if (dat_o !== 32'd0) begin errors++; $display("FAIL dat_idle: got %h expected 0", dat_o); end
    endtask

    task automatic test_trim();
        logic [31:0] r;
        int lat;
        wb_xfer(1'b1, 32'h3000_0008, 32'h1234_ABCD, 4'b0001, r, lat);
        checks++; if (trim !== 16'h00CD) begin errors++; $display("FAIL trim_lane0: got %h expected 00cd", trim); end
        wb_xfer(1'b0, 32'h3000_0008, 32'd0, 4'hF, r, lat);
        checks++; if (r !== 32'h0000_00CD) begin errors++; $display("FAIL trim_rd: got %h expected 000000cd", r); end
        wb_xfer(1'b1, 32'h3000_0008, 32'h0000_5500, 4'b0010, r, lat);
        checks++; if (trim !== 16'h55CD) begin errors++; $display("FAIL trim_lane1: got %h expected 55cd", trim); end
    endtask

    task automatic test_ctrl();
        logic [31:0] r;
        int lat;
        wb_xfer(1'b1, 32'h3000_0004, 32'hFFFF_FFA5, 4'hF, r, lat);
        checks++; if (ctrl !== 8'hA5) begin errors++; $display("FAIL ctrl_wr: got %h expected a5", ctrl); end
        wb_xfer(1'b0, 32'h3000_0004, 32'd0, 4'hF, r, lat);
        checks++; if (r !== 32'h0000_00A5) begin errors++; $display("FAIL ctrl_rd: got %h expected 000000a5", r); end
    endtask

    task automatic test_unmapped();
        logic [31:0] r;
        int lat;
        wb_xfer(1'b1, 32'h3000_0040, 32'hDEAD_BEEF, 4'hF, r, lat);
        wb_xfer(1'b0, 32'h3000_0040, 32'd0, 4'hF, r, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL unmapped_ack: got %0d expected 1", lat); end
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL unmapped_rd: got %h expected 0", r); end
    endtask

    task automatic test_status();
        logic [31:0] r;
        int lat;
        @(negedge wb_clk_i);
        status = 4'b1010;
        wb_xfer(1'b0, 32'h3000_000C, 32'd0, 4'hF, r, lat);
        checks++; if (r !== 32'h0000_000A) begin errors++; $display("FAIL status_rd: got %h expected 0000000a", r); end
        wb_xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF, r, lat);
        checks++; if (r !== 32'h0000_000A) begin errors++; $display("FAIL status_edges: got %h expected 0000000a", r); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL status_masked_irq: got %b expected 0", irq); end
        status = 4'b0000;
        wb_xfer(1'b1, 32'h3000_0010, 32'h1F, 4'b0001, r, lat);
        wb_xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF, r, lat);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL status_w1c: got %h expected 0", r); end
    endtask

    task automatic test_irq();
        logic [31:0] r;
        int lat;
        wb_xfer(1'b1, 32'h3000_0014, 32'h01, 4'hF, r, lat);
        @(negedge wb_clk_i);
        status = 4'b0001;
        @(posedge wb_clk_i); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_delay: got %b expected 0", irq); end
        @(posedge wb_clk_i); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq); end
        wb_xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF, r, lat);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL irq_stat: got %h expected 1", r); end
        status = 4'b0000;
        @(posedge wb_clk_i);
        // W1C lands in the same cycle as a fresh rising edge.
        @(negedge wb_clk_i);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0010; dat = 32'h1; sel = 4'b0001;
        status = 4'b0001;
        @(posedge wb_clk_i); #1;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL irq_w1c_ack: got %b expected 1", ack); end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge wb_clk_i); #1;
        wb_xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF, r, lat);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL irq_set_wins: got %h expected 1", r); end
        wb_xfer(1'b1, 32'h3000_0010, 32'h1, 4'b0001, r, lat);
        wb_xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF, r, lat);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL irq_clear: got %h expected 0", r); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b expected 0", irq); end
        status = 4'b0000;
    endtask

    task automatic test_no_match();
        logic seen;
        seen = 1'b0;
        @(negedge wb_clk_i);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_1000; sel = 4'hF;
        repeat (8) begin
            @(posedge wb_clk_i); #1;
            if (ack !== 1'b0) seen = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL no_match_ack: got %b expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        @(negedge wb_clk_i);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0004; sel = 4'hF;
        pat[0] = ack;
        for (int i = 1; i < 4; i++) begin
            @(posedge wb_clk_i); #1;
            pat[i] = ack;
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge wb_clk_i); #1;
        checks++; if (pat !== 4'b1010) begin errors++; $display("FAIL b2b_pattern: got %b expected 1010 (msb last)", pat); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        int lat;
        @(negedge wb_clk_i);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0004; dat = 32'hFF; sel = 4'hF;
        @(posedge wb_clk_i); #1;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL abort_ack_in: got %b expected 1", ack); end
        wb_rst_i = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge wb_clk_i); #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL abort_ack_next: got %b expected 0", ack); end
        checks++; if (ctrl !== 8'd0) begin errors++; $display("FAIL abort_ctrl: got %h expected 0", ctrl); end
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        wb_xfer(1'b0, 32'h3000_0004, 32'd0, 4'hF, r, lat);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL abort_ctrl_rd: got %h expected 0", r); end
    endtask

    initial begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 32'd0; dat = 32'd0; sel = 4'd0;
        status = 4'd0;
        wb_rst_i = 1'b1;
        test_reset();
        test_timer();
        test_id();
        test_trim();
        test_ctrl();
        test_unmapped();
        test_status();
        test_irq();
        test_no_match();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
